// File: rtl/intersection_pkg.sv
// Shared types and constants for the two-road intersection controller.
// The PW state exists only when INTERSECTION_PED_EN is defined.
package intersection_pkg;

    typedef enum logic [2:0] {
        StMg  = 3'd0,
        StMy  = 3'd1,
        StAr1 = 3'd2,
        StSg  = 3'd3,
        StSy  = 3'd4,
        StAr2 = 3'd5
`ifdef INTERSECTION_PED_EN
        ,
        StPw  = 3'd6
`endif
    } state_e;

    // Lamp vectors are {red, yellow, green}.
    localparam logic [2:0] LampG = 3'b001;
    localparam logic [2:0] LampY = 3'b010;
    localparam logic [2:0] LampR = 3'b100;

    localparam int unsigned MainGreenMinDef = 20;
    localparam int unsigned SideGreenMinDef = 5;
    localparam int unsigned SideGreenMaxDef = 15;
    localparam int unsigned YellowTDef      = 3;
    localparam int unsigned AllRedTDef      = 1;
    localparam int unsigned WalkTDef        = 10;
    localparam int unsigned CamHoldDef      = 2;

endpackage

// File: rtl/intersection_ctrl_red_light_camera.sv
// Red-light violation detector: camera strobe with restartable hold and a
// saturating violation counter.
module red_light_camera
    import intersection_pkg::*;
#(
    parameter int unsigned CAM_HOLD = CamHoldDef
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] main_lamp_i,
    input  logic [2:0] side_lamp_i,
    input  logic       cross_main_i,
    input  logic       cross_side_i,
    output logic       camera_o,
    output logic [7:0] viol_cnt_o
);

    localparam int unsigned HoldW = $clog2(CAM_HOLD + 1);

    logic             viol;
    logic [HoldW-1:0] hold_d, hold_q;
    logic [7:0]       cnt_d, cnt_q;

    // Both roads violating in the same cycle is a single event.
    assign viol = (cross_main_i && (main_lamp_i == LampR)) ||
                  (cross_side_i && (side_lamp_i == LampR));

    always_comb begin
        hold_d = hold_q;
        cnt_d  = cnt_q;
        if (viol) begin
            hold_d = HoldW'(CAM_HOLD);
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
            cnt_q  <= '0;
        end else begin
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
        end
    end

    assign camera_o   = (hold_q != '0);
    assign viol_cnt_o = cnt_q;

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection sequencer (Moore FSM) with red-light camera.
// Define INTERSECTION_PED_EN to add the pedestrian walk phase.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int unsigned MAIN_GREEN_MIN = MainGreenMinDef,
    parameter int unsigned SIDE_GREEN_MIN = SideGreenMinDef,
    parameter int unsigned SIDE_GREEN_MAX = SideGreenMaxDef,
    parameter int unsigned YELLOW_T       = YellowTDef,
    parameter int unsigned ALL_RED_T      = AllRedTDef,
`ifdef INTERSECTION_PED_EN
    parameter int unsigned WALK_T         = WalkTDef,
`endif
    parameter int unsigned CAM_HOLD       = CamHoldDef
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_side,
    input  logic       cross_main,
    input  logic       cross_side,
`ifdef INTERSECTION_PED_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic       main_green,
    output logic       main_yellow,
    output logic       main_red,
    output logic       side_green,
    output logic       side_yellow,
    output logic       side_red,
    output logic       camera,
    output logic [7:0] viol_cnt
);

    // Last elapsed value of each timed phase.
    localparam logic [7:0] MgMinLast  = 8'(MAIN_GREEN_MIN - 1);
    localparam logic [7:0] SgMinLast  = 8'(SIDE_GREEN_MIN - 1);
    localparam logic [7:0] SgMaxLast  = 8'(SIDE_GREEN_MAX - 1);
    localparam logic [7:0] YellowLast = 8'(YELLOW_T - 1);
    localparam logic [7:0] AllRedLast = 8'(ALL_RED_T - 1);
`ifdef INTERSECTION_PED_EN
    localparam logic [7:0] WalkLast   = 8'(WALK_T - 1);
`endif

    state_e     state_d, state_q;
    logic [7:0] elapsed_d, elapsed_q;
    logic       side_req_d, side_req_q;
    logic       ped_any;
    logic [2:0] main_lamp, side_lamp;

`ifdef INTERSECTION_PED_EN
    logic ped_pend_d, ped_pend_q;
    assign ped_any = ped_pend_q || ped_req;
`else
    assign ped_any = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StMg;
            elapsed_q  <= '0;
            side_req_q <= 1'b0;
`ifdef INTERSECTION_PED_EN
            ped_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            elapsed_q  <= elapsed_d;
            side_req_q <= side_req_d;
`ifdef INTERSECTION_PED_EN
            ped_pend_q <= ped_pend_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StMg: begin
                if (elapsed_q >= MgMinLast && (side_req_q || s_side || ped_any)) begin
                    state_d = StMy;
                end
            end
            StMy: if (elapsed_q == YellowLast) state_d = StAr1;
            StAr1: begin
                if (elapsed_q == AllRedLast) begin
                    if (side_req_q) begin
                        state_d = StSg;
`ifdef INTERSECTION_PED_EN
                    end else if (ped_pend_q) begin
                        state_d = StPw;
`endif
                    end else begin
                        state_d = StMg;
                    end
                end
            end
            StSg: begin
                if (elapsed_q == SgMaxLast || (elapsed_q >= SgMinLast && !s_side)) begin
                    state_d = StSy;
                end
            end
            StSy: if (elapsed_q == YellowLast) state_d = StAr2;
            StAr2: begin
                if (elapsed_q == AllRedLast) begin
`ifdef INTERSECTION_PED_EN
                    state_d = ped_pend_q ? StPw : StMg;
`else
                    state_d = StMg;
`endif
                end
            end
`ifdef INTERSECTION_PED_EN
            StPw: if (elapsed_q == WalkLast) state_d = StMg;
`endif
            default: state_d = StMg;
        endcase
    end

    always_comb begin
        elapsed_d = elapsed_q;
        if (state_d != state_q) begin
            elapsed_d = '0;
        end else if (elapsed_q != 8'hFF) begin
            elapsed_d = elapsed_q + 8'd1;
        end

        // Clearing on entry wins over a same-cycle sensor set.
        side_req_d = side_req_q;
        if (state_d == StSg && state_q != StSg) begin
            side_req_d = 1'b0;
        end else if (s_side && state_q != StSg) begin
            side_req_d = 1'b1;
        end

`ifdef INTERSECTION_PED_EN
        ped_pend_d = ped_pend_q;
        if (state_d == StPw && state_q != StPw) begin
            ped_pend_d = 1'b0;
        end else if (ped_req && state_q != StPw) begin
            ped_pend_d = 1'b1;
        end
`endif
    end

    always_comb begin
        main_lamp = LampG;
        side_lamp = LampR;
        unique case (state_q)
            StMg: begin main_lamp = LampG; side_lamp = LampR; end
            StMy: begin main_lamp = LampY; side_lamp = LampR; end
            StSg: begin main_lamp = LampR; side_lamp = LampG; end
            StSy: begin main_lamp = LampR; side_lamp = LampY; end
            StAr1, StAr2: begin main_lamp = LampR; side_lamp = LampR; end
`ifdef INTERSECTION_PED_EN
            StPw: begin main_lamp = LampR; side_lamp = LampR; end
`endif
            default: begin main_lamp = LampG; side_lamp = LampR; end
        endcase
    end

    assign main_green  = main_lamp[0];
    assign main_yellow = main_lamp[1];
    assign main_red    = main_lamp[2];
    assign side_green  = side_lamp[0];
    assign side_yellow = side_lamp[1];
    assign side_red    = side_lamp[2];
`ifdef INTERSECTION_PED_EN
    assign walk = (state_q == StPw);
`endif

    red_light_camera #(
        .CAM_HOLD(CAM_HOLD)
    ) u_camera (
        .clk_i       (clk),
        .rst_i       (rst),
        .main_lamp_i (main_lamp),
        .side_lamp_i (side_lamp),
        .cross_main_i(cross_main),
        .cross_side_i(cross_side),
        .camera_o    (camera),
        .viol_cnt_o  (viol_cnt)
    );

endmodule

// File: doc/intersection_ctrl.md
# intersection_ctrl

Sequences a two-road intersection: a main road and a sensor-triggered side road, each with a green/yellow/red lamp set. A Moore state machine with a phase-elapsed counter enforces minimum and maximum green times, yellow and all-red clearance. A red-light camera block flags vehicles crossing on red and counts violations. It sits above the single-lamp traffic light, drives both lamp sets, and uses the same clock: clk at 1 Hz, so 1 cycle = 1 s.

## Interface
- MAIN_GREEN_MIN, 20: minimum main-green cycles
- SIDE_GREEN_MIN, 5: minimum side-green cycles
- SIDE_GREEN_MAX, 15: maximum side-green cycles
- YELLOW_T, 3: yellow cycles, both roads
- ALL_RED_T, 1: all-red clearance cycles
- WALK_T, 10: pedestrian walk cycles (INTERSECTION_PED_EN only)
- CAM_HOLD, 2: camera pulse length in cycles
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_side  in  1  side-road vehicle sensor, level
- cross_main  in  1  main-road stop-line crossing
- cross_side  in  1  side-road stop-line crossing
- ped_req  in  1  pedestrian button, pulse or level (INTERSECTION_PED_EN only)
- main_green, main_yellow, main_red  out  1 each  main lamps
- side_green, side_yellow, side_red  out  1 each  side lamps
- walk  out  1  pedestrian walk lamp (INTERSECTION_PED_EN only)
- camera  out  1  violation capture strobe
- viol_cnt  out  8  violation count, saturating

## Operation
- States: MG, MY, AR1, SG, SY, AR2, PW.
  - PW exists only with INTERSECTION_PED_EN.
- Lamps are a combinational decode of the state register.
  - MG: main green, side red. MY: main yellow, side red.
  - SG: side green, main red. SY: side yellow, main red.
  - AR1, AR2, PW: both roads red. walk=1 only in PW.
- Exactly one lamp per road is lit at all times.
- elapsed: 8-bit counter, saturating.
  - 0 on the first cycle of each state, +1 per cycle.
- side_req latch:
  - Set by s_side=1 in any state except SG.
  - Cleared on the edge entering SG.
- ped_pend latch:
  - Set by ped_req in any state except PW.
  - Cleared on the edge entering PW.
- Transitions (the condition is evaluated in the current cycle; the move happens at the next edge):
  - MG→MY: elapsed ≥ MAIN_GREEN_MIN−1 and (side_req or s_side or ped_pend or ped_req).
  - MY→AR1: elapsed = YELLOW_T−1.
  - AR1→SG, AR1→PW or AR1→MG, at elapsed = ALL_RED_T−1:
    - SG if side_req.
    - Otherwise PW if ped_pend.
    - Otherwise MG.
  - SG→SY: elapsed = SIDE_GREEN_MAX−1, or (elapsed ≥ SIDE_GREEN_MIN−1 and s_side=0).
  - SY→AR2: elapsed = YELLOW_T−1.
  - AR2→PW or AR2→MG, at elapsed = ALL_RED_T−1: PW if ped_pend, else MG.
  - PW→MG: elapsed = WALK_T−1.
- Service order after main green: side road first, then pedestrians.
- Violation condition: (cross_main and main_red) or (cross_side and side_red).
  - Crossing on yellow is not a violation.
  - Simultaneous main and side violations count once.
- On a violation:
  - camera=1 for the next CAM_HOLD cycles.
  - A new violation during the hold restarts the hold.
  - viol_cnt increments by 1 and saturates at 255.

## Timing
- Reset values: state MG, elapsed 0, side_req 0, ped_pend 0, camera 0, viol_cnt 0.
  - Lamps at reset: main_green=1, side_red=1, all others 0, walk=0.
- rst asserted mid-phase (any state) forces reset values at the next edge. Lamps show MG the cycle after rst is sampled.
- Each timed state lasts exactly its parameter in cycles.
- Lamp change latency: 0 cycles after the state edge.
- Camera latency: 1 cycle after the violation is sampled.
- viol_cnt updates on the same edge the camera rises.
- A request arriving in the same cycle that MG reaches its minimum is honoured that cycle; there is no latch latency.

## Configuration
- INTERSECTION_PED_EN defined:
  - ped_req and walk ports, the PW state, the ped_pend latch and WALK_T are all present.
- INTERSECTION_PED_EN undefined:
  - ped_req and walk ports, the PW state, the ped_pend latch and WALK_T are removed.
  - AR1 exits to SG if side_req, else MG. AR2 always exits to MG.

## Structure
- Shared package intersection_pkg:
  - State enum.
  - Lamp-vector constants (R/Y/G one-hot).
  - Default timing constants.
- Sub-module red_light_camera:
  - Contains the violation detect, hold counter and saturating viol_cnt.
  - Takes the lamp-state and crossing inputs.

## Test plan
- Reset, then s_side=0 and no crossings for 100 cycles → main_green=1, side_red=1 every cycle, camera=0.
- Hold s_side=1 from cycle 3 → MG cycles 0–19, MY 20–22, AR1 23, SG 24–38 (max), SY 39–41, AR2 42, MG 43.
- Pulse s_side=1 at cycle 30 only → MY 31–33, AR1 34, SG 35–39 (minimum 5), SY 40–42, AR2 43, MG 44.
- Pulse cross_side=1 at cycle 5 (during MG) → camera=1 cycles 6–7, viol_cnt=1. Pulse cross_main=1 during MY → no camera, viol_cnt stays 1.
- rst=1 for one cycle during SG at cycle 30 → cycle 31: main_green=1, side_red=1, viol_cnt=0, elapsed restarts.
- INTERSECTION_PED_EN: pulse ped_req at cycle 2 → MY 20–22, AR1 23, PW 24–33 with walk=1, MG 34.
